// File: rtl/clic_irq_receiver.sv
// -----------------------------------------------------------------------------
// clic_irq_receiver
//
// Core-side end of the CLIC interrupt handshake. An interrupt offered by the
// CLIC (valid + id/level/mode/v/shv) is captured into local registers, gated
// against the hart's global enables, thresholds and current interrupt levels,
// and presented to the pipeline as a qualified request. The CLIC sees either
// irq_ready_o (the core took the interrupt) or irq_kill_ack_o (the handoff was
// abandoned at the CLIC's request).
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   irq_valid_i / irq_ready_o  CLIC handshake (completes on valid & ready)
//   irq_id_i, irq_level_i,
//   irq_mode_i, irq_v_i,
//   irq_shv_i                  interrupt attributes from the CLIC
//   irq_kill_req_i/_ack_o      CLIC request to abandon the handoff / grant
//   priv_lvl_i                 current hart privilege (11=M, 01=S, 00=U)
//   mie_i, sie_i               mstatus.MIE / mstatus.SIE
//   mil_i, sil_i               current M / S interrupt level
//   mthresh_i, sthresh_i       M / S interrupt thresholds
//   core_irq_req_o             qualified request to the pipeline
//   core_irq_*_o               captured interrupt attributes
//   core_irq_ack_i             pipeline accepts the request
//   core_irq_busy_i            pipeline committed to trap entry (blocks kill)
// -----------------------------------------------------------------------------
module clic_irq_receiver #(
  parameter int N_SOURCE  = 256,
  parameter int PrioWidth = 8,
  parameter int ModeWidth = 2,
  localparam int SrcWidth = $clog2(N_SOURCE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 irq_valid_i,
  output logic                 irq_ready_o,
  input  logic [SrcWidth-1:0]  irq_id_i,
  input  logic [PrioWidth-1:0] irq_level_i,
  input  logic [ModeWidth-1:0] irq_mode_i,
  input  logic                 irq_v_i,
  input  logic                 irq_shv_i,
  input  logic                 irq_kill_req_i,
  output logic                 irq_kill_ack_o,

  input  logic [1:0]           priv_lvl_i,
  input  logic                 mie_i,
  input  logic                 sie_i,
  input  logic [PrioWidth-1:0] mil_i,
  input  logic [PrioWidth-1:0] sil_i,
  input  logic [PrioWidth-1:0] mthresh_i,
  input  logic [PrioWidth-1:0] sthresh_i,

  output logic                 core_irq_req_o,
  output logic [SrcWidth-1:0]  core_irq_id_o,
  output logic [PrioWidth-1:0] core_irq_level_o,
  output logic [ModeWidth-1:0] core_irq_mode_o,
  output logic                 core_irq_v_o,
  output logic                 core_irq_shv_o,
  input  logic                 core_irq_ack_i,
  input  logic                 core_irq_busy_i
);

  localparam logic [1:0]           PrivM = 2'b11;
  localparam logic [1:0]           PrivU = 2'b00;
  localparam logic [ModeWidth-1:0] ModeM = ModeWidth'(3);
  localparam logic [ModeWidth-1:0] ModeS = ModeWidth'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_reg, state_next;

  logic [SrcWidth-1:0]  id_reg;
  logic [PrioWidth-1:0] level_reg;
  logic [ModeWidth-1:0] mode_reg;
  logic                 v_reg;
  logic                 shv_reg;
  logic                 capture;

  // ---------------------------------------------------------------------------
  // Eligibility: the captured level must exceed both the current level of the
  // target mode and that mode's threshold. A lower-privilege hart is always
  // interruptible by a higher target mode regardless of its enable bit.
  // ---------------------------------------------------------------------------
  logic [PrioWidth-1:0] m_floor;
  logic [PrioWidth-1:0] s_floor;
  logic                 elig_m;
  logic                 elig_s;
  logic                 eligible;

  assign m_floor  = (mil_i > mthresh_i) ? mil_i : mthresh_i;
  assign s_floor  = (sil_i > sthresh_i) ? sil_i : sthresh_i;

  assign elig_m   = ((priv_lvl_i != PrivM) || mie_i) && (level_reg > m_floor);
  assign elig_s   = (priv_lvl_i != PrivM) && ((priv_lvl_i == PrivU) || sie_i) &&
                    (level_reg > s_floor);

  // U-mode and the reserved encoding are never taken by this hart.
  assign eligible = ((mode_reg == ModeM) && elig_m) ||
                    ((mode_reg == ModeS) && elig_s);

  // ---------------------------------------------------------------------------
  // Handshake outputs. Ready wins over kill so the CLIC never sees both.
  // ---------------------------------------------------------------------------
  assign core_irq_req_o = (state_reg == PEND) && irq_valid_i && eligible;
  assign irq_ready_o    = core_irq_req_o && core_irq_ack_i;
  assign irq_kill_ack_o = (state_reg == PEND) && irq_kill_req_i &&
                          !core_irq_busy_i && !irq_ready_o;

  assign core_irq_id_o    = id_reg;
  assign core_irq_level_o = level_reg;
  assign core_irq_mode_o  = mode_reg;
  assign core_irq_v_o     = v_reg;
  assign core_irq_shv_o   = shv_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (irq_valid_i) begin
          capture    = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        if (irq_ready_o || irq_kill_ack_o) begin
          // Fields stay frozen so the pipeline sees the accepted interrupt.
          state_next = DONE;
        end else if (!irq_valid_i) begin
          // Level interrupt cleared underneath us: drop quietly.
          state_next = IDLE;
        end else begin
          // Keep tracking the CLIC so mnxti-driven id changes are followed.
          capture    = 1'b1;
        end
      end
      DONE: begin
        // Guard cycle: the CLIC has not yet deasserted valid for the old id.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and captured-field registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      level_reg <= '0;
      mode_reg  <= '0;
      v_reg     <= 1'b0;
      shv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        id_reg    <= irq_id_i;
        level_reg <= irq_level_i;
        mode_reg  <= irq_mode_i;
        v_reg     <= irq_v_i;
        shv_reg   <= irq_shv_i;
      end
    end
  end

endmodule

// File: tb/tb_clic_irq_receiver.sv
// -----------------------------------------------------------------------------
// tb_clic_irq_receiver
//
// Directed scenarios followed by a randomized run. A transaction-level model
// tracks the interrupt the core currently holds and whether it is being
// offered or cooling down, and predicts req/ready/kill_ack/fields every cycle.
// -----------------------------------------------------------------------------
module tb_clic_irq_receiver;

  logic       clk = 1'b0;
  logic       rst_ni;
  always #5 clk = ~clk;

  logic       irq_valid, irq_ready, irq_v, irq_shv, irq_kill_req, irq_kill_ack;
  logic [7:0] irq_id, irq_level;
  logic [1:0] irq_mode, priv_lvl;
  logic       mie, sie;
  logic [7:0] mil, sil, mthresh, sthresh;
  logic       core_req, core_v, core_shv, core_ack, core_busy;
  logic [7:0] core_id, core_level;
  logic [1:0] core_mode;

  clic_irq_receiver dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .irq_valid_i      (irq_valid),
    .irq_ready_o      (irq_ready),
    .irq_id_i         (irq_id),
    .irq_level_i      (irq_level),
    .irq_mode_i       (irq_mode),
    .irq_v_i          (irq_v),
    .irq_shv_i        (irq_shv),
    .irq_kill_req_i   (irq_kill_req),
    .irq_kill_ack_o   (irq_kill_ack),
    .priv_lvl_i       (priv_lvl),
    .mie_i            (mie),
    .sie_i            (sie),
    .mil_i            (mil),
    .sil_i            (sil),
    .mthresh_i        (mthresh),
    .sthresh_i        (sthresh),
    .core_irq_req_o   (core_req),
    .core_irq_id_o    (core_id),
    .core_irq_level_o (core_level),
    .core_irq_mode_o  (core_mode),
    .core_irq_v_o     (core_v),
    .core_irq_shv_o   (core_shv),
    .core_irq_ack_i   (core_ack),
    .core_irq_busy_i  (core_busy)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] id;
    logic [7:0] lvl;
    logic [1:0] mode;
    logic       v;
    logic       shv;
  } rec_t;

  rec_t held;      // attributes the core is currently holding
  bit   offered;   // an interrupt is being offered to the pipeline
  bit   cooling;   // one cycle after a taken/killed handoff
  bit   exp_req, exp_ready, exp_kill;

  function automatic rec_t inputs_now();
    rec_t r;
    r.id   = irq_id;
    r.lvl  = irq_level;
    r.mode = irq_mode;
    r.v    = irq_v;
    r.shv  = irq_shv;
    return r;
  endfunction

  function automatic bit takeable(rec_t r);
    int bar;
    if (r.mode == 2'b11) begin
      bar = (mil > mthresh) ? int'(mil) : int'(mthresh);
      return ((priv_lvl != 2'b11) || mie) && (int'(r.lvl) > bar);
    end
    if (r.mode == 2'b01) begin
      bar = (sil > sthresh) ? int'(sil) : int'(sthresh);
      if (priv_lvl == 2'b11) return 1'b0;
      return ((priv_lvl == 2'b00) || sie) && (int'(r.lvl) > bar);
    end
    return 1'b0;
  endfunction

  // Compare all outputs against the model, away from the active edge.
  task automatic sample();
    @(negedge clk);
    exp_req   = offered && irq_valid && takeable(held);
    exp_ready = exp_req && core_ack;
    exp_kill  = offered && irq_kill_req && !core_busy && !exp_ready;
    chk("req",      32'(core_req),     32'(exp_req));
    chk("ready",    32'(irq_ready),    32'(exp_ready));
    chk("kill_ack", 32'(irq_kill_ack), 32'(exp_kill));
    chk("fields",   32'({core_id, core_level, core_mode, core_v, core_shv}), 32'(held));
    chk("exclusive", 32'(irq_ready & irq_kill_ack), 32'd0);
  endtask

  // Move the model across the clock edge using the inputs of this cycle.
  task automatic advance();
    @(posedge clk);
    if (cooling) begin
      cooling = 1'b0;
    end else if (!offered) begin
      if (irq_valid) begin
        held    = inputs_now();
        offered = 1'b1;
      end
    end else if (exp_ready || exp_kill) begin
      offered = 1'b0;
      cooling = 1'b1;
    end else if (!irq_valid) begin
      offered = 1'b0;
    end else begin
      held = inputs_now();
    end
    #1;
  endtask

  task automatic quiet(input int n);
    irq_valid = 0; irq_kill_req = 0; core_ack = 0; core_busy = 0;
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic offer(input logic [7:0] id, input logic [7:0] lvl, input logic [1:0] mode);
    irq_valid = 1; irq_id = id; irq_level = lvl; irq_mode = mode;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({core_req, irq_ready, irq_kill_ack, core_id, core_level,
                  core_mode, core_v, core_shv}), 32'd0);
  endtask

  initial begin
    irq_valid = 0; irq_id = 0; irq_level = 0; irq_mode = 0; irq_v = 0; irq_shv = 0;
    irq_kill_req = 0; priv_lvl = 2'b11; mie = 1; sie = 1;
    mil = 0; sil = 0; mthresh = 0; sthresh = 0; core_ack = 0; core_busy = 0;
    held = '0; offered = 0; cooling = 0;

    // Reset state
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
    quiet(2);

    // 1: basic take, M-mode, ack two cycles after req
    offer(8'd5, 8'h80, 2'b11); irq_v = 1; irq_shv = 1;
    sample(); chk("t1_idle_req", 32'(core_req), 0); advance();
    sample(); chk("t1_req", 32'(core_req), 1); chk("t1_id", 32'(core_id), 5);
    chk("t1_vshv", 32'({core_v, core_shv}), 32'b11); advance();
    sample(); advance();
    core_ack = 1;
    sample(); chk("t1_ready", 32'(irq_ready), 1); advance();
    core_ack = 0; irq_id = 8'd6;
    sample(); chk("t1_done_req", 32'(core_req), 0); chk("t1_held", 32'(core_id), 5); advance();
    sample(); chk("t1_idle_again", 32'(core_req), 0); advance();
    sample(); chk("t1_recapture", 32'(core_id), 6); chk("t1_req2", 32'(core_req), 1); advance();
    irq_v = 0; irq_shv = 0;
    quiet(2);

    // 2: threshold boundary, level equal to threshold is not enough
    mthresh = 8'h40;
    offer(8'd3, 8'h40, 2'b11);
    sample(); advance();
    sample(); chk("t2_eq_thresh", 32'(core_req), 0); advance();
    mthresh = 8'h3F;
    sample(); chk("t2_below_thresh", 32'(core_req), 1);
    chk("t2_no_ack_no_ready", 32'(irq_ready), 0); advance();
    mthresh = 0;
    quiet(2);

    // 3: kill while ineligible, then new id captured after the guard cycle
    offer(8'd4, 8'h80, 2'b11);
    sample(); advance();
    mie = 0; irq_kill_req = 1;
    sample(); chk("t3_kill", 32'(irq_kill_ack), 1); chk("t3_req", 32'(core_req), 0); advance();
    irq_kill_req = 0; mie = 1; irq_id = 8'd9;
    sample(); chk("t3_done", 32'(core_req), 0); advance();
    sample(); advance();
    sample(); chk("t3_new_id", 32'(core_id), 9); chk("t3_new_req", 32'(core_req), 1); advance();
    quiet(2);

    // 4: kill held off while pipeline busy
    offer(8'd2, 8'h80, 2'b11);
    sample(); advance();
    irq_kill_req = 1; core_busy = 1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("t4_busy_kill", 32'(irq_kill_ack), 0); advance();
    end
    core_busy = 0;
    sample(); chk("t4_kill_after_busy", 32'(irq_kill_ack), 1); advance();
    quiet(2);

    // 5: ready beats kill
    offer(8'd11, 8'h90, 2'b11);
    sample(); advance();
    core_ack = 1; irq_kill_req = 1;
    sample(); chk("t5_ready", 32'(irq_ready), 1); chk("t5_kill", 32'(irq_kill_ack), 0); advance();
    quiet(2);

    // 6: id tracking, then valid withdrawn
    offer(8'd5, 8'h80, 2'b11);
    sample(); advance();
    irq_id = 8'd7;
    sample(); chk("t6_old_id", 32'(core_id), 5); advance();
    sample(); chk("t6_new_id", 32'(core_id), 7); advance();
    irq_valid = 0; core_ack = 1;
    sample(); chk("t6_drop_req", 32'(core_req), 0); chk("t6_drop_ready", 32'(irq_ready), 0); advance();
    core_ack = 0; offer(8'd8, 8'h80, 2'b11);
    sample(); chk("t6_idle", 32'(core_req), 0); advance();
    sample(); chk("t6_recapture", 32'(core_id), 8); advance();
    quiet(2);

    // 7: S-mode target from U and from S with SIE clear
    priv_lvl = 2'b00; sie = 0; sthresh = 8'h10;
    offer(8'd20, 8'h11, 2'b01);
    sample(); advance();
    sample(); chk("t7_s_from_u", 32'(core_req), 1); advance();
    priv_lvl = 2'b01;
    sample(); chk("t7_s_from_s_sie0", 32'(core_req), 0); advance();
    priv_lvl = 2'b11; sie = 1; sthresh = 0;
    quiet(2);

    // 8: reset in the middle of an offered interrupt
    offer(8'd33, 8'hF0, 2'b11);
    sample(); advance();
    sample(); chk("t8_req_before", 32'(core_req), 1); advance();
    irq_valid = 0;
    rst_ni = 1'b0;
    #1 chk_all_zero("t8_midreset");
    held = '0; offered = 0; cooling = 0;
    @(negedge clk) rst_ni = 1'b1;
    advance();
    quiet(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (irq_valid) irq_valid = ($urandom_range(0, 9) != 0);
      else           irq_valid = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 4) == 0) irq_id = 8'($urandom_range(0, 255));
      if (!irq_valid || $urandom_range(0, 7) == 0) begin
        irq_level = 8'($urandom_range(0, 255));
        irq_mode  = 2'($urandom_range(0, 3));
        irq_v     = 1'($urandom_range(0, 1));
        irq_shv   = 1'($urandom_range(0, 1));
      end
      core_ack     = ($urandom_range(0, 2) == 0);
      irq_kill_req = ($urandom_range(0, 7) == 0);
      core_busy    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        priv_lvl = 2'($urandom_range(0, 3));
        mie      = 1'($urandom_range(0, 1));
        sie      = 1'($urandom_range(0, 1));
        mil      = 8'($urandom_range(0, 127));
        sil      = 8'($urandom_range(0, 127));
        mthresh  = 8'($urandom_range(0, 127));
        sthresh  = 8'($urandom_range(0, 127));
      end
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
